// File: rtl/moore_seq_pkg.sv
// Shared types and helpers for the Moore colour sequencer.
// Mode encodings follow the 2-bit board switch code directly.
package moore_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_FWD  = 2'b01,
    MODE_REV  = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic is_run(input mode_e m);
    return (m == MODE_FWD) || (m == MODE_REV);
  endfunction

endpackage

// File: rtl/moore_color_sequencer_dwell_timer.sv
// Dwell timer: counts 0..DWELL_CYCLES-1 while enabled.
// tick is decoded from the count register only.
module seq_dwell_timer
  import moore_seq_pkg::*;
#(
  parameter int DWELL_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = clog2_min1(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] TERM =
    CNT_W'(DWELL_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = (cnt_q == TERM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/moore_color_sequencer.sv
// Moore colour sequencer: one-hot LED drive stepped by mode and dwell.
// Define MOORE_SEQ_SW_SYNC_EN to add a 2-flop synchroniser on sw.
module moore_color_sequencer
  import moore_seq_pkg::*;
#(
  parameter  int NUM_COLORS   = 3,
  parameter  int DWELL_CYCLES = 4,
  localparam int IDX_W        = clog2_min1(NUM_COLORS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            sw,
  output logic [NUM_COLORS-1:0] color_oh,
  output logic [IDX_W-1:0]      color_idx,
  output logic                  active,
  output logic                  wrap
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_COLORS - 1);

  logic [1:0]       sw_s;
  mode_e            mode_q, mode_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  logic             wrap_q, wrap_nxt;
  logic             dwell_clr, dwell_en, tick;

`ifdef MOORE_SEQ_SW_SYNC_EN
  logic [1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
    end
  end

  assign sw_s = sync2_q;
`else
  assign sw_s = sw;
`endif

  always_comb begin
    mode_nxt = MODE_OFF;
    unique case (sw_s)
      2'b01:   mode_nxt = MODE_FWD;
      2'b10:   mode_nxt = MODE_REV;
      2'b11:   mode_nxt = MODE_HOLD;
      default: mode_nxt = MODE_OFF;
    endcase
  end

  seq_dwell_timer #(
    .DWELL_CYCLES (DWELL_CYCLES)
  ) u_dwell (
    .clk    (clk),
    .reset  (reset),
    .clear  (dwell_clr),
    .enable (dwell_en),
    .tick   (tick)
  );

  // Count only while the mode is steady in a run direction.
  always_comb begin
    idx_nxt   = idx_q;
    wrap_nxt  = 1'b0;
    dwell_clr = 1'b0;
    dwell_en  = 1'b0;
    if (mode_q == MODE_OFF || mode_nxt == MODE_OFF) begin
      idx_nxt   = '0;
      dwell_clr = 1'b1;
    end else if (is_run(mode_q) && is_run(mode_nxt)
                 && mode_q != mode_nxt) begin
      dwell_clr = 1'b1;
    end else if (is_run(mode_q) && mode_nxt == mode_q) begin
      dwell_en = 1'b1;
      if (tick) begin
        unique case (1'b1)
          (mode_q == MODE_FWD): begin
            if (idx_q == LAST) begin
              idx_nxt  = '0;
              wrap_nxt = 1'b1;
            end else begin
              idx_nxt = idx_q + IDX_W'(1);
            end
          end
          (mode_q == MODE_REV): begin
            if (idx_q == '0) begin
              idx_nxt  = LAST;
              wrap_nxt = 1'b1;
            end else begin
              idx_nxt = idx_q - IDX_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= MODE_OFF;
      idx_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      mode_q <= mode_nxt;
      idx_q  <= idx_nxt;
      wrap_q <= wrap_nxt;
    end
  end

  assign active    = (mode_q != MODE_OFF);
  assign color_idx = idx_q;
  assign wrap      = wrap_q;
  assign color_oh  = active
                   ? (NUM_COLORS'(1) << idx_q)
                   : '0;

endmodule

// File: tb/tb_moore_color_sequencer.sv
// Scoreboard bench for moore_color_sequencer (3x4 and 5x1 instances).
// Expected outputs are queued per cycle and popped as cycles elapse.
module tb_moore_color_sequencer;

`ifdef MOORE_SEQ_SW_SYNC_EN
  localparam int SH = 2;
`else
  localparam int SH = 0;
`endif

  typedef struct {
    int         cyc;
    int         unit;
    logic [4:0] oh;
    logic [3:0] idx;
    logic       act;
    logic       wrp;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [1:0] sw, sw5;
  logic [2:0] oh;
  logic [1:0] idx;
  logic       act, wrap;
  logic [4:0] oh5;
  logic [2:0] idx5;
  logic       act5, wrap5;

  exp_t exp_q[$];
  int   errors;
  int   checks;

  moore_color_sequencer #(
    .NUM_COLORS   (3),
    .DWELL_CYCLES (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .color_oh  (oh),
    .color_idx (idx),
    .active    (act),
    .wrap      (wrap)
  );

  moore_color_sequencer #(
    .NUM_COLORS   (5),
    .DWELL_CYCLES (1)
  ) dut5 (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw5),
    .color_oh  (oh5),
    .color_idx (idx5),
    .active    (act5),
    .wrap      (wrap5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(int c, int u, logic [4:0] o,
                              logic [3:0] i, logic a, logic w);
    exp_t e;
    e.cyc = c; e.unit = u; e.oh = o;
    e.idx = i; e.act = a; e.wrp = w;
    return e;
  endfunction

  function automatic logic [10:0] got_vec(int u);
    if (u == 1) return {oh5, 1'b0, idx5, act5, wrap5};
    return {2'b00, oh, 2'b00, idx, act, wrap};
  endfunction

  task automatic start();
    reset = 1'b0;
    sw    = 2'b00;
    sw5   = 2'b00;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [10:0] g;
    start();
    for (int c = 1; c <= 10; c++)
      exp_q.push_back(mk(c, 0, 5'b0, 4'd0, 1'b0, 1'b0));
    for (int n = 0; n <= 10; n++) begin
      if (n > 0) @(posedge clk);
      #1;
      if (n == 0) begin
        g = got_vec(0);
        checks++;
        if (g !== 11'b0) begin
          errors++;
          $display("FAIL reset_state got=%b exp=%b", g, 11'b0);
        end
      end
      while (exp_q.size() > 0 && exp_q[0].cyc == n) begin
        e = exp_q.pop_front();
        g = got_vec(e.unit);
        checks++;
        if (g !== {e.oh, e.idx, e.act, e.wrp}) begin
          errors++;
          $display("FAIL off_hold c=%0d got=%b exp=%b",
                   n, g, {e.oh, e.idx, e.act, e.wrp});
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL off_left got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_fwd();
    exp_t e;
    logic [10:0] g;
    start();
    sw = 2'b01;
    exp_q.push_back(mk(SH,    0, 5'b000, 4'd0, 1'b0, 1'b0));
    exp_q.push_back(mk(SH+1,  0, 5'b001, 4'd0, 1'b1, 1'b0));
    exp_q.push_back(mk(SH+4,  0, 5'b001, 4'd0, 1'b1, 1'b0));
    exp_q.push_back(mk(SH+5,  0, 5'b010, 4'd1, 1'b1, 1'b0));
    exp_q.push_back(mk(SH+8,  0, 5'b010, 4'd1, 1'b1, 1'b0));
    exp_q.push_back(mk(SH+9,  0, 5'b100, 4'd2, 1'b1, 1'b0));
    exp_q.push_back(mk(SH+12, 0, 5'b100, 4'd2, 1'b1, 1'b0));
    exp_q.push_back(mk(SH+13, 0, 5'b001, 4'd0, 1'b1, 1'b1));
    exp_q.push_back(mk(SH+14, 0, 5'b001, 4'd0, 1'b1, 1'b0));
    for (int n = 0; n <= SH + 15; n++) begin
      if (n > 0) @(posedge clk);
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc == n) begin
        e = exp_q.pop_front();
        g = got_vec(e.unit);
        checks++;
        if (g !== {e.oh, e.idx, e.act, e.wrp}) begin
          errors++;
          $display("FAIL fwd c=%0d got=%b exp=%b",
                   n, g, {e.oh, e.idx, e.act, e.wrp});
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL fwd_left got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_rev();
    exp_t e;
    logic [10:0] g;
    start();
    sw = 2'b10;
    exp_q.push_back(mk(SH+1, 0, 5'b001, 4'd0, 1'b1, 1'b0));
    exp_q.push_back(mk(SH+4, 0, 5'b001, 4'd0, 1'b1, 1'b0));
    exp_q.push_back(mk(SH+5, 0, 5'b100, 4'd2, 1'b1, 1'b1));
    exp_q.push_back(mk(SH+6, 0, 5'b100, 4'd2, 1'b1, 1'b0));
    exp_q.push_back(mk(SH+9, 0, 5'b010, 4'd1, 1'b1, 1'b0));
    for (int n = 0; n <= SH + 10; n++) begin
      if (n > 0) @(posedge clk);
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc == n) begin
        e = exp_q.pop_front();
        g = got_vec(e.unit);
        checks++;
        if (g !== {e.oh, e.idx, e.act, e.wrp}) begin
          errors++;
          $display("FAIL rev c=%0d got=%b exp=%b",
                   n, g, {e.oh, e.idx, e.act, e.wrp});
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rev_left got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_hold();
    exp_t e;
    logic [10:0] g;
    start();
    sw = 2'b01;
    exp_q.push_back(mk(SH+6,  0, 5'b010, 4'd1, 1'b1, 1'b0));
    exp_q.push_back(mk(SH+7,  0, 5'b010, 4'd1, 1'b1, 1'b0));
    exp_q.push_back(mk(SH+20, 0, 5'b010, 4'd1, 1'b1, 1'b0));
    exp_q.push_back(mk(SH+27, 0, 5'b010, 4'd1, 1'b1, 1'b0));
    exp_q.push_back(mk(SH+29, 0, 5'b010, 4'd1, 1'b1, 1'b0));
    exp_q.push_back(mk(SH+30, 0, 5'b100, 4'd2, 1'b1, 1'b0));
    for (int n = 0; n <= SH + 31; n++) begin
      if (n > 0) @(posedge clk);
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc == n) begin
        e = exp_q.pop_front();
        g = got_vec(e.unit);
        checks++;
        if (g !== {e.oh, e.idx, e.act, e.wrp}) begin
          errors++;
          $display("FAIL hold c=%0d got=%b exp=%b",
                   n, g, {e.oh, e.idx, e.act, e.wrp});
        end
      end
      if (n == 6)  sw = 2'b11;
      if (n == 26) sw = 2'b01;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL hold_left got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_dir_switch();
    exp_t e;
    logic [10:0] g;
    start();
    sw = 2'b01;
    exp_q.push_back(mk(SH+7,  0, 5'b010, 4'd1, 1'b1, 1'b0));
    exp_q.push_back(mk(SH+10, 0, 5'b010, 4'd1, 1'b1, 1'b0));
    exp_q.push_back(mk(SH+11, 0, 5'b001, 4'd0, 1'b1, 1'b0));
    exp_q.push_back(mk(SH+14, 0, 5'b001, 4'd0, 1'b1, 1'b0));
    exp_q.push_back(mk(SH+15, 0, 5'b100, 4'd2, 1'b1, 1'b1));
    for (int n = 0; n <= SH + 16; n++) begin
      if (n > 0) @(posedge clk);
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc == n) begin
        e = exp_q.pop_front();
        g = got_vec(e.unit);
        checks++;
        if (g !== {e.oh, e.idx, e.act, e.wrp}) begin
          errors++;
          $display("FAIL dir_sw c=%0d got=%b exp=%b",
                   n, g, {e.oh, e.idx, e.act, e.wrp});
        end
      end
      if (n == 6) sw = 2'b10;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL dir_left got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    logic [10:0] g;
    start();
    sw = 2'b01;
    exp_q.push_back(mk(SH+9, 0, 5'b100, 4'd2, 1'b1, 1'b0));
    for (int n = 0; n <= SH + 10; n++) begin
      if (n > 0) @(posedge clk);
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc == n) begin
        e = exp_q.pop_front();
        g = got_vec(e.unit);
        checks++;
        if (g !== {e.oh, e.idx, e.act, e.wrp}) begin
          errors++;
          $display("FAIL pre_rst c=%0d got=%b exp=%b",
                   n, g, {e.oh, e.idx, e.act, e.wrp});
        end
      end
    end
    #2 reset = 1'b0;
    #1;
    g = got_vec(0);
    checks++;
    if (g !== 11'b0) begin
      errors++;
      $display("FAIL async_rst got=%b exp=%b", g, 11'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(mk(SH+1, 0, 5'b001, 4'd0, 1'b1, 1'b0));
    exp_q.push_back(mk(SH+5, 0, 5'b010, 4'd1, 1'b1, 1'b0));
    for (int n = 1; n <= SH + 6; n++) begin
      @(posedge clk);
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc == n) begin
        e = exp_q.pop_front();
        g = got_vec(e.unit);
        checks++;
        if (g !== {e.oh, e.idx, e.act, e.wrp}) begin
          errors++;
          $display("FAIL post_rst c=%0d got=%b exp=%b",
                   n, g, {e.oh, e.idx, e.act, e.wrp});
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rst_left got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_dwell1();
    exp_t e;
    logic [10:0] g;
    start();
    sw5 = 2'b01;
    exp_q.push_back(mk(SH,   1, 5'b00000, 4'd0, 1'b0, 1'b0));
    exp_q.push_back(mk(SH+1, 1, 5'b00001, 4'd0, 1'b1, 1'b0));
    exp_q.push_back(mk(SH+2, 1, 5'b00010, 4'd1, 1'b1, 1'b0));
    exp_q.push_back(mk(SH+3, 1, 5'b00100, 4'd2, 1'b1, 1'b0));
    exp_q.push_back(mk(SH+4, 1, 5'b01000, 4'd3, 1'b1, 1'b0));
    exp_q.push_back(mk(SH+5, 1, 5'b10000, 4'd4, 1'b1, 1'b0));
    exp_q.push_back(mk(SH+6, 1, 5'b00001, 4'd0, 1'b1, 1'b1));
    exp_q.push_back(mk(SH+7, 1, 5'b00010, 4'd1, 1'b1, 1'b0));
    for (int n = 0; n <= SH + 8; n++) begin
      if (n > 0) @(posedge clk);
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc == n) begin
        e = exp_q.pop_front();
        g = got_vec(e.unit);
        checks++;
        if (g !== {e.oh, e.idx, e.act, e.wrp}) begin
          errors++;
          $display("FAIL dwell1 c=%0d got=%b exp=%b",
                   n, g, {e.oh, e.idx, e.act, e.wrp});
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL d1_left got=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    sw     = 2'b00;
    sw5    = 2'b00;
    test_reset();
    test_fwd();
    test_rev();
    test_hold();
    test_dir_switch();
    test_async_reset();
    test_dwell1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/moore_color_sequencer.md
Name: moore_color_sequencer

Overview:
- Parametrised Moore sequencer that steps a one-hot colour output through NUM_COLORS entries under switch-selected mode control.
- Modes are off, auto-forward, auto-reverse and hold; automatic stepping is paced by a dwell timer.
- Sits between the board switch inputs and the LED drivers; it is the next generation of the fixed 3-colour switch FSM.

Parameters:
- NUM_COLORS, 3, number of colour outputs; legal range 2..16.
- DWELL_CYCLES, 4, clock cycles spent on each colour in the run modes; minimum 1.
- Localparam IDX_W = $clog2(NUM_COLORS), minimum 1.
- Localparam CNT_W = $clog2(DWELL_CYCLES), minimum 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low.
- sw  input  2  mode request: 00 OFF, 01 RUN_FWD, 10 RUN_REV, 11 HOLD.
- color_oh  output  NUM_COLORS  one-hot colour drive; all zero when OFF.
- color_idx  output  IDX_W  current colour index.
- active  output  1  high in every mode except OFF.
- wrap  output  1  one-cycle pulse in the cycle after idx wraps (either direction).

Behaviour:
- Reset (reset=0, async):
  - mode=OFF, idx=0, dwell_cnt=0, wrap=0.
  - Therefore color_oh=0, color_idx=0, active=0.
- Moore outputs: all outputs are decoded only from registers (mode, idx, wrap_q). No combinational path from sw to any output.
  - color_oh = (1<<idx) when mode!=OFF, else 0.
- Mode register: loads the decoded sw on every clk edge. An sw change is visible on the outputs 1 cycle later (3 cycles with SW_SYNC_EN).
- OFF:
  - idx forced to 0; dwell_cnt forced to 0.
  - Leaving OFF always starts at colour 0 with a full dwell.
- RUN_FWD:
  - dwell_cnt counts 0..DWELL_CYCLES-1.
  - At terminal count: dwell_cnt->0 and idx->idx+1.
  - idx NUM_COLORS-1 -> 0 sets wrap for exactly 1 cycle.
- RUN_REV:
  - Same timing as RUN_FWD; idx->idx-1.
  - idx 0 -> NUM_COLORS-1 sets wrap for 1 cycle.
- HOLD: idx and dwell_cnt are frozen (not cleared); a return to RUN resumes the partial dwell.
- Step timing: the first step occurs DWELL_CYCLES cycles after the mode register enters RUN from OFF.
- DWELL_CYCLES=1: idx changes every cycle while running.
- FWD<->REV direct switch: dwell_cnt cleared to 0 in the same edge; idx unchanged; no step on that edge.
- HOLD->RUN: no dwell clear.
- Non-power-of-2 NUM_COLORS: idx must never take values >= NUM_COLORS; wrap is by explicit compare, not by overflow.
- Reset asserted mid-run: all state returns to reset values immediately (async); first active edge after release behaves as from OFF.
- Unreachable mode encodings: none exist (2-bit fully decoded). Default branch goes to OFF.

Optional Feature:
- Macro: MOORE_SEQ_SW_SYNC_EN.
- Defined: sw passes through a 2-flop synchroniser, reset to 2'b00, before mode decode; sw->output latency becomes 3 cycles.
- Undefined: sw is sampled directly; latency 1 cycle. Intended for synchronous testbench or internal-driven use only.

Decomposition:
- Package moore_seq_pkg:
  - Mode encodings MODE_OFF=2'b00, MODE_FWD=2'b01, MODE_REV=2'b10, MODE_HOLD=2'b11.
  - Function clog2_min1.
- One sub-module, seq_dwell_timer:
  - Parameter DWELL_CYCLES.
  - Inputs clear and enable; output tick at terminal count.
  - Top level owns the mode and idx registers.

Test Plan (NUM_COLORS=3, DWELL_CYCLES=4, macro undefined unless stated):
1. Reset, then sw=00 for 10 cycles -> color_oh=000, active=0, color_idx=0 throughout.
2. sw=01 from cycle 0 -> active=1 at cycle 1 with color_oh=001; 010 at cycle 5; 100 at cycle 9; 001 at cycle 13 with wrap=1 for cycle 13 only.
3. sw=10 from OFF -> color_oh 001, then 100 after 4 cycles with a wrap pulse, then 010 after 4 more.
4. sw=01 for 6 cycles (idx=1, dwell 1 of 4 used), sw=11 for 20 cycles, sw=01 -> idx stays 1 during HOLD; steps to 2 exactly 3 cycles after leaving HOLD.
5. Running at idx=2, pull reset low between clock edges -> outputs 000/0 immediately without an edge; after release with sw=01, restarts at 001.
6. Macro MOORE_SEQ_SW_SYNC_EN defined, sw 00->01 -> active rises on the 3rd edge after the sw change; also rerun scenario 2 with NUM_COLORS=5 and DWELL_CYCLES=1 -> idx sequence 0,1,2,3,4,0 with wrap at the last step.
